// File: rtl/ysyx_rdc_pkg.sv
// Shared types and defaults for the redirect/flush controller.
package ysyx_rdc_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int PMU_W_DEF = 32;

  typedef enum logic [2:0] {IDLE, DRAIN_F, DRAIN_I, INV_REQ, INV_WAIT, REDIR} rdc_state_t;
  typedef enum logic [2:0] {NONE, TRAP, FENCEI, FENCE, FLUSH} rdc_evt_t;

  // Fixed priority: timer trap wins, then fence.i, fence, plain flush.
  function automatic rdc_evt_t sel_evt(input logic trap, input logic fi,
                                       input logic ft, input logic fp);
    if (trap)    return TRAP;
    else if (fi) return FENCEI;
    else if (ft) return FENCE;
    else if (fp) return FLUSH;
    else         return NONE;
  endfunction

endpackage

// File: rtl/ysyx_rdc_pmu.sv
// Flush/fence.i/busy-cycle counters, present only with YSYX_RDC_PMU_EN.
module ysyx_rdc_pmu #(
  parameter int PMU_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             accept,
  input  logic             fencei,
  input  logic             busy,
  output logic [PMU_W-1:0] pmu_flush_cnt,
  output logic [PMU_W-1:0] pmu_fencei_cnt,
  output logic [PMU_W-1:0] pmu_busy_cyc
);

  always_ff @(posedge clock) begin
    if (reset) begin
      pmu_flush_cnt  <= '0;
      pmu_fencei_cnt <= '0;
      pmu_busy_cyc   <= '0;
    end else begin
      if (accept)          pmu_flush_cnt  <= pmu_flush_cnt + 1'b1;
      if (accept && fencei) pmu_fencei_cnt <= pmu_fencei_cnt + 1'b1;
      if (busy)            pmu_busy_cyc   <= pmu_busy_cyc + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_rdc.sv
// Redirect/flush controller after commit: flush, drain, I$ invalidate, IFU redirect.
// Optional counters under YSYX_RDC_PMU_EN.
module ysyx_rdc
  import ysyx_rdc_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int PMU_W = PMU_W_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cmt_valid,
  input  logic [XLEN-1:0] cmt_cpc,
  input  logic            cmt_flush_pipe,
  input  logic            cmt_fence_i,
  input  logic            cmt_fence_time,
  input  logic            cmt_time_trap,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            sb_empty,
  input  logic            ic_inv_ready,
  input  logic            ic_inv_done,
  input  logic            ifu_ready,
  output logic            flush,
  output logic            busy,
  output logic            ic_inv_valid,
  output logic            ifu_redirect_valid,
`ifdef YSYX_RDC_PMU_EN
  output logic [PMU_W-1:0] pmu_flush_cnt,
  output logic [PMU_W-1:0] pmu_fencei_cnt,
  output logic [PMU_W-1:0] pmu_busy_cyc,
`endif
  output logic [XLEN-1:0] ifu_redirect_pc
);

  rdc_state_t      state, state_n;
  rdc_evt_t        evt;
  logic [XLEN-1:0] target;

  assign busy = (state != IDLE);

  always_comb begin
    evt                = NONE;
    state_n            = state;
    ic_inv_valid       = 1'b0;
    ifu_redirect_valid = 1'b0;
    ifu_redirect_pc    = '0;
    if (state == IDLE && cmt_valid && !reset)
      evt = sel_evt(cmt_time_trap, cmt_fence_i, cmt_fence_time, cmt_flush_pipe);
    flush = (evt != NONE);
    case (state)
      IDLE: begin
        case (evt)
          TRAP, FLUSH: state_n = REDIR;
          FENCE:       state_n = DRAIN_F;
          FENCEI:      state_n = DRAIN_I;
          default:     state_n = IDLE;
        endcase
      end
      DRAIN_F: if (sb_empty) state_n = REDIR;
      DRAIN_I: if (sb_empty) state_n = INV_REQ;
      INV_REQ: begin
        ic_inv_valid = 1'b1;
        // A done pulse coincident with the handshake completes the invalidate.
        if (ic_inv_ready) state_n = ic_inv_done ? REDIR : INV_WAIT;
      end
      INV_WAIT: if (ic_inv_done) state_n = REDIR;
      REDIR: begin
        ifu_redirect_valid = 1'b1;
        ifu_redirect_pc    = target;
        if (ifu_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      target <= '0;
    end else begin
      state <= state_n;
      if (flush) target <= (evt == TRAP) ? trap_pc : cmt_cpc;
    end
  end

  // Commit must hold off while busy; such a broadcast is dropped.
  always_ff @(posedge clock)
    if (!reset) assert (!(busy && cmt_valid))
      else $warning("ysyx_rdc: cmt_valid while busy ignored");

`ifdef YSYX_RDC_PMU_EN
  ysyx_rdc_pmu #(.PMU_W(PMU_W)) u_pmu (
    .clock         (clock),
    .reset         (reset),
    .accept        (flush),
    .fencei        (evt == FENCEI),
    .busy          (busy),
    .pmu_flush_cnt (pmu_flush_cnt),
    .pmu_fencei_cnt(pmu_fencei_cnt),
    .pmu_busy_cyc  (pmu_busy_cyc)
  );
`endif

endmodule

// File: tb/tb_ysyx_rdc.sv
// Directed bench for ysyx_rdc; outs = {flush, busy, ic_inv_valid, ifu_redirect_valid}.
module tb_ysyx_rdc;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmt_valid = 0, cmt_flush_pipe = 0, cmt_fence_i = 0, cmt_fence_time = 0, cmt_time_trap = 0;
  logic [31:0] cmt_cpc = '0, trap_pc = '0;
  logic        sb_empty = 0, ic_inv_ready = 0, ic_inv_done = 0, ifu_ready = 0;
  logic        flush, busy, ic_inv_valid, ifu_redirect_valid;
  logic [31:0] ifu_redirect_pc;
  logic [3:0]  outs;
`ifdef YSYX_RDC_PMU_EN
  logic [31:0] pmu_flush_cnt, pmu_fencei_cnt, pmu_busy_cyc;
`endif
  int n_tests = 0;
  int n_fail  = 0;

  assign outs = {flush, busy, ic_inv_valid, ifu_redirect_valid};

  always #5 clock = ~clock;

  ysyx_rdc dut (
    .clock(clock), .reset(reset), .cmt_valid(cmt_valid), .cmt_cpc(cmt_cpc),
    .cmt_flush_pipe(cmt_flush_pipe), .cmt_fence_i(cmt_fence_i),
    .cmt_fence_time(cmt_fence_time), .cmt_time_trap(cmt_time_trap),
    .trap_pc(trap_pc), .sb_empty(sb_empty), .ic_inv_ready(ic_inv_ready),
    .ic_inv_done(ic_inv_done), .ifu_ready(ifu_ready), .flush(flush), .busy(busy),
    .ic_inv_valid(ic_inv_valid), .ifu_redirect_valid(ifu_redirect_valid),
`ifdef YSYX_RDC_PMU_EN
    .pmu_flush_cnt(pmu_flush_cnt), .pmu_fencei_cnt(pmu_fencei_cnt), .pmu_busy_cyc(pmu_busy_cyc),
`endif
    .ifu_redirect_pc(ifu_redirect_pc)
  );

  // Inputs change at posedge+1; checks happen at posedge+2.
  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic clr_cmt;
    cmt_valid = 0; cmt_flush_pipe = 0; cmt_fence_i = 0; cmt_fence_time = 0; cmt_time_trap = 0;
  endtask

  task automatic test_reset;
    reset = 1; tick; tick; reset = 0; #1;
    n_tests++; if (outs !== 4'b0000) begin n_fail++; $display("FAIL reset_outs got=%b exp=%b", outs, 4'b0000); end
    n_tests++; if (ifu_redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", ifu_redirect_pc, 32'h0); end
    tick; sb_empty = 1; ic_inv_ready = 1; ifu_ready = 1; #1;
    n_tests++; if (outs !== 4'b0000) begin n_fail++; $display("FAIL idle_no_valid got=%b exp=%b", outs, 4'b0000); end
  endtask

  task automatic test_flush_pipe;
    tick; cmt_valid = 1; cmt_flush_pipe = 1; cmt_cpc = 32'h8000_0100; ifu_ready = 1; #1;
    n_tests++; if (outs !== 4'b1000) begin n_fail++; $display("FAIL fp_accept got=%b exp=%b", outs, 4'b1000); end
    tick; clr_cmt; #1;
    n_tests++; if (outs !== 4'b0101) begin n_fail++; $display("FAIL fp_redir got=%b exp=%b", outs, 4'b0101); end
    n_tests++; if (ifu_redirect_pc !== 32'h8000_0100) begin n_fail++; $display("FAIL fp_pc got=%h exp=%h", ifu_redirect_pc, 32'h8000_0100); end
    tick; #1;
    n_tests++; if (outs !== 4'b0000) begin n_fail++; $display("FAIL fp_idle got=%b exp=%b", outs, 4'b0000); end
  endtask

  task automatic test_priority;
    cmt_valid = 1; cmt_time_trap = 1; cmt_flush_pipe = 1; cmt_fence_i = 1; cmt_fence_time = 1;
    trap_pc = 32'h8000_0004; cmt_cpc = 32'h8000_0200; #1;
    n_tests++; if (outs !== 4'b1000) begin n_fail++; $display("FAIL prio_accept got=%b exp=%b", outs, 4'b1000); end
    tick; clr_cmt; #1;
    n_tests++; if (outs !== 4'b0101) begin n_fail++; $display("FAIL prio_redir got=%b exp=%b", outs, 4'b0101); end
    n_tests++; if (ifu_redirect_pc !== 32'h8000_0004) begin n_fail++; $display("FAIL prio_pc got=%h exp=%h", ifu_redirect_pc, 32'h8000_0004); end
    tick; #1;
    n_tests++; if (outs !== 4'b0000) begin n_fail++; $display("FAIL prio_idle got=%b exp=%b", outs, 4'b0000); end
  endtask

  task automatic test_fence;
    sb_empty = 0; cmt_valid = 1; cmt_fence_time = 1; cmt_cpc = 32'h8000_0300; #1;
    n_tests++; if (outs !== 4'b1000) begin n_fail++; $display("FAIL fence_accept got=%b exp=%b", outs, 4'b1000); end
    tick; clr_cmt;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++; if (outs !== 4'b0100) begin n_fail++; $display("FAIL fence_drain%0d got=%b exp=%b", i, outs, 4'b0100); end
      tick;
    end
    sb_empty = 1; #1;
    n_tests++; if (outs !== 4'b0100) begin n_fail++; $display("FAIL fence_sb_edge got=%b exp=%b", outs, 4'b0100); end
    tick; #1;
    n_tests++; if (outs !== 4'b0101) begin n_fail++; $display("FAIL fence_redir got=%b exp=%b", outs, 4'b0101); end
    n_tests++; if (ifu_redirect_pc !== 32'h8000_0300) begin n_fail++; $display("FAIL fence_pc got=%h exp=%h", ifu_redirect_pc, 32'h8000_0300); end
    tick; #1;
    n_tests++; if (outs !== 4'b0000) begin n_fail++; $display("FAIL fence_idle got=%b exp=%b", outs, 4'b0000); end
    // Minimum latency with everything ready: accept, DRAIN_F, REDIR, IDLE.
    cmt_valid = 1; cmt_fence_time = 1; tick; clr_cmt; #1;
    n_tests++; if (outs !== 4'b0100) begin n_fail++; $display("FAIL fence_min_drain got=%b exp=%b", outs, 4'b0100); end
    tick; tick; #1;
    n_tests++; if (outs !== 4'b0000) begin n_fail++; $display("FAIL fence_min_idle got=%b exp=%b", outs, 4'b0000); end
  endtask

  task automatic test_fence_i;
    ic_inv_ready = 0; ifu_ready = 0; cmt_valid = 1; cmt_fence_i = 1; cmt_cpc = 32'h8000_0400; #1;
    n_tests++; if (outs !== 4'b1000) begin n_fail++; $display("FAIL fi_accept got=%b exp=%b", outs, 4'b1000); end
    tick; clr_cmt; #1;
    n_tests++; if (outs !== 4'b0100) begin n_fail++; $display("FAIL fi_drain got=%b exp=%b", outs, 4'b0100); end
    tick;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) ic_inv_ready = 1;
      #1;
      n_tests++; if (outs !== 4'b0110) begin n_fail++; $display("FAIL fi_invreq%0d got=%b exp=%b", i, outs, 4'b0110); end
      tick;
    end
    ic_inv_ready = 0; #1;
    n_tests++; if (outs !== 4'b0100) begin n_fail++; $display("FAIL fi_invwait got=%b exp=%b", outs, 4'b0100); end
    tick; ic_inv_done = 1; tick; ic_inv_done = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) ifu_ready = 1;
      #1;
      n_tests++; if (outs !== 4'b0101) begin n_fail++; $display("FAIL fi_redir%0d got=%b exp=%b", i, outs, 4'b0101); end
      n_tests++; if (ifu_redirect_pc !== 32'h8000_0400) begin n_fail++; $display("FAIL fi_pc%0d got=%h exp=%h", i, ifu_redirect_pc, 32'h8000_0400); end
      tick;
    end
    #1;
    n_tests++; if (outs !== 4'b0000) begin n_fail++; $display("FAIL fi_idle got=%b exp=%b", outs, 4'b0000); end
    // Minimum latency: done coincident with the invalidate handshake.
    ic_inv_ready = 1; ic_inv_done = 1; cmt_valid = 1; cmt_fence_i = 1;
    tick; clr_cmt; tick; #1;
    n_tests++; if (outs !== 4'b0110) begin n_fail++; $display("FAIL fi_min_req got=%b exp=%b", outs, 4'b0110); end
    tick; #1;
    n_tests++; if (outs !== 4'b0101) begin n_fail++; $display("FAIL fi_min_redir got=%b exp=%b", outs, 4'b0101); end
    tick; ic_inv_done = 0; #1;
    n_tests++; if (outs !== 4'b0000) begin n_fail++; $display("FAIL fi_min_idle got=%b exp=%b", outs, 4'b0000); end
  endtask

  task automatic test_busy_ignore;
    ifu_ready = 0; cmt_valid = 1; cmt_flush_pipe = 1; cmt_cpc = 32'h8000_0500;
    tick; cmt_time_trap = 1; trap_pc = 32'h8000_0044; #1;
    n_tests++; if (outs !== 4'b0101) begin n_fail++; $display("FAIL busy_no_flush got=%b exp=%b", outs, 4'b0101); end
    tick; clr_cmt; ifu_ready = 1; #1;
    n_tests++; if (outs !== 4'b0101) begin n_fail++; $display("FAIL busy_state got=%b exp=%b", outs, 4'b0101); end
    n_tests++; if (ifu_redirect_pc !== 32'h8000_0500) begin n_fail++; $display("FAIL busy_pc got=%h exp=%h", ifu_redirect_pc, 32'h8000_0500); end
    tick; #1;
    n_tests++; if (outs !== 4'b0000) begin n_fail++; $display("FAIL busy_idle got=%b exp=%b", outs, 4'b0000); end
  endtask

  task automatic test_reset_mid;
    ic_inv_done = 0; ic_inv_ready = 1; cmt_valid = 1; cmt_fence_i = 1; cmt_cpc = 32'h8000_0600;
    tick; clr_cmt; tick; tick; #1;
    n_tests++; if (outs !== 4'b0100) begin n_fail++; $display("FAIL rst_invwait got=%b exp=%b", outs, 4'b0100); end
    reset = 1; tick; reset = 0; ic_inv_done = 1; #1;
    n_tests++; if (outs !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_outs got=%b exp=%b", outs, 4'b0000); end
    tick; ic_inv_done = 0; #1;
    n_tests++; if (outs !== 4'b0000) begin n_fail++; $display("FAIL rst_no_complete got=%b exp=%b", outs, 4'b0000); end
    n_tests++; if (ifu_redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got=%h exp=%h", ifu_redirect_pc, 32'h0); end
  endtask

`ifdef YSYX_RDC_PMU_EN
  task automatic test_pmu;
    reset = 1; tick; reset = 0;
    sb_empty = 1; ic_inv_ready = 1; ic_inv_done = 1; ifu_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cmt_valid = 1; cmt_fence_i = 1; tick; clr_cmt; tick; tick; tick;
    end
    for (int i = 0; i < 2; i++) begin
      cmt_valid = 1; cmt_flush_pipe = 1; tick; clr_cmt; tick;
    end
    ic_inv_done = 0; #1;
    n_tests++; if (pmu_flush_cnt !== 32'd5) begin n_fail++; $display("FAIL pmu_flush got=%0d exp=%0d", pmu_flush_cnt, 5); end
    n_tests++; if (pmu_fencei_cnt !== 32'd3) begin n_fail++; $display("FAIL pmu_fencei got=%0d exp=%0d", pmu_fencei_cnt, 3); end
    n_tests++; if (pmu_busy_cyc !== 32'd11) begin n_fail++; $display("FAIL pmu_busy got=%0d exp=%0d", pmu_busy_cyc, 11); end
  endtask
`endif

  initial begin
    test_reset;
    test_flush_pipe;
    test_priority;
    test_fence;
    test_fence_i;
    test_busy_ignore;
    test_reset_mid;
`ifdef YSYX_RDC_PMU_EN
    test_pmu;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_rdc.md
Name: ysyx_rdc

Overview:
- Redirect/flush controller sitting directly after the commit unit.
- Consumes the per-retire commit broadcast (flush_pipe, fence_i, fence_time, time_trap, correct pc) and sequences the recovery actions:
  - backend flush pulse
  - store-buffer drain wait
  - I-cache invalidate handshake
  - IFU redirect handshake
- Holds commit stalled (busy) until the sequence completes, so at most one recovery is in flight.

Parameters:
- XLEN, `YSYX_XLEN (32): address width.
- PMU_W, 32: width of flush/stall counters (optional feature only).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmt_valid  in  1  commit broadcast valid this cycle
- cmt_cpc  in  XLEN  correct next pc of the retiring instruction
- cmt_flush_pipe  in  1  retiring inst requires pipeline flush and refetch at cmt_cpc
- cmt_fence_i  in  1  retiring inst is fence.i
- cmt_fence_time  in  1  retiring inst is fence (memory ordering)
- cmt_time_trap  in  1  timer interrupt taken at this retire
- trap_pc  in  XLEN  trap vector target (mtvec-derived), sampled with the event
- sb_empty  in  1  store buffer drained
- ic_inv_ready  in  1  I-cache accepts invalidate request
- ic_inv_done  in  1  I-cache invalidate complete (1-cycle pulse)
- ifu_ready  in  1  IFU accepts redirect
- flush  out  1  backend flush pulse (ROU/RS/LSU/rename)
- busy  out  1  stall commit; high in every non-IDLE state
- ic_inv_valid  out  1  invalidate request
- ifu_redirect_valid  out  1  redirect request
- ifu_redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset: state=IDLE; every output 0; the latched target register is 0.
- Event selection in IDLE when cmt_valid=1, fixed priority: time_trap > fence_i > fence_time > flush_pipe.
  - The winner's target is latched: trap_pc for time_trap, cmt_cpc otherwise.
  - Lower-priority flags in the same cycle are discarded; the retiring instruction's own requirement is subsumed by the refetch.
- flush: asserted combinationally for exactly the IDLE cycle that accepts any event. Never asserted outside IDLE.
- State transitions (registered, from IDLE on an accepted event):
  - time_trap, flush_pipe -> REDIR
  - fence_time -> DRAIN_F
  - fence_i -> DRAIN_I
- DRAIN_F: wait for sb_empty=1, then -> REDIR. If sb_empty is already 1, the transition still takes one cycle (minimum 1 cycle in DRAIN_F).
- DRAIN_I: wait for sb_empty=1, then -> INV_REQ.
- INV_REQ: ic_inv_valid=1, held until ic_inv_ready=1 in the same cycle. Then -> INV_WAIT.
- INV_WAIT: wait for ic_inv_done. Then -> REDIR.
  - ic_inv_done arriving in the same cycle as the INV_REQ handshake: treat as done and go directly to REDIR.
- REDIR:
  - ifu_redirect_valid=1 and ifu_redirect_pc=latched target, held stable until ifu_ready.
  - On handshake -> IDLE. busy drops in the following cycle.
- busy = (state != IDLE). Commit must not present cmt_valid while busy.
  - cmt_valid while busy is ignored (no flush, no state change).
  - Simulation assertion fires on this condition.
- Minimum latencies, event accept to IDLE with all ready signals already high:
  - flush_pipe / trap: 2 cycles
  - fence_time: 3 cycles
  - fence_i: 4 cycles
- reset asserted mid-sequence: returns to IDLE next edge; outstanding inv/redirect requests are dropped with no completion.
- cmt_valid=0 in IDLE: no action, all outputs 0.

Optional Feature:
- Macro: YSYX_RDC_PMU_EN.
- Defined:
  - Three PMU_W-bit counters, all reset to 0, wrapping at 2^PMU_W:
    - pmu_flush_cnt: +1 per accepted event
    - pmu_fencei_cnt: +1 per fence_i accepted
    - pmu_busy_cyc: +1 per busy cycle
  - Counters exported as extra output ports.
  - $display of event kind and target on each accept when DPI debug is on.
- Undefined: counters and ports absent; behaviour otherwise identical.

Decomposition:
- Shared package (ysyx package / ysyx.svh): rdc_state_t enum (IDLE, DRAIN_F, DRAIN_I, INV_REQ, INV_WAIT, REDIR); rdc_evt_t enum (NONE, TRAP, FENCEI, FENCE, FLUSH).
- One natural sub-module: ysyx_rdc_pmu, holding the counters, instantiated only under YSYX_RDC_PMU_EN.
- Priority select and FSM stay inline.

Test Plan:
- flush_pipe, cpc=0x8000_0100, ifu_ready=1 -> flush pulse at cycle 0; redirect valid with pc 0x8000_0100 at cycle 1; busy low at cycle 2.
- time_trap+flush_pipe same cycle, trap_pc=0x8000_0004 -> single flush; redirect pc 0x8000_0004.
- fence_time with sb_empty=0 for 5 cycles -> no redirect until sb_empty; redirect 1 cycle after sb_empty=1.
- fence_i, ic_inv_ready low 3 cycles, done 2 cycles after accept -> ic_inv_valid held 4 cycles; redirect after done; ifu_ready low 2 cycles -> pc stable throughout.
- cmt_valid while busy -> no second flush, state unchanged, assertion triggers; reset in INV_WAIT -> IDLE, all outputs 0 next cycle.
- PMU build: 3 fence_i + 2 flush_pipe events -> pmu_flush_cnt=5, pmu_fencei_cnt=3.
